kbd_arrow_decoder: RTL and testbench

//  PS/2 keyboard front end that produces the 4-bit arrow-key vector consumed by the car motion controller.

---
 rtl/kbd_pkg.sv | 40 ++++
 rtl/kbd_arrow_decoder_ps2_rx.sv | 150 +++++++++++++++
 rtl/kbd_arrow_decoder.sv | 111 +++++++++++
 tb/tb_kbd_arrow_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard constants: arrow bit masks, scancodes, receiver state type.
// Masks are shared with car control; KBD_WASD_EN makes the SC_W/A/S/D codes active in the decoder.
package kbd_pkg;

   localparam logic [3:0] ARROW_UP    = 4'b0001;
   localparam logic [3:0] ARROW_DOWN  = 4'b0010;
   localparam logic [3:0] ARROW_LEFT  = 4'b0100;
   localparam logic [3:0] ARROW_RIGHT = 4'b1000;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_BAT_OK  = 8'hAA;
   localparam logic [7:0] SC_BAT_ERR = 8'hFC;
   localparam logic [7:0] SC_UP      = 8'h75;
   localparam logic [7:0] SC_DOWN    = 8'h72;
   localparam logic [7:0] SC_LEFT    = 8'h6B;
   localparam logic [7:0] SC_RIGHT   = 8'h74;
   localparam logic [7:0] SC_W       = 8'h1D;
   localparam logic [7:0] SC_S       = 8'h1B;
   localparam logic [7:0] SC_A       = 8'h1C;
   localparam logic [7:0] SC_D       = 8'h23;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   // Opposite directions cancel so the motion controller never sees up+down or left+right.
   function automatic logic [3:0] cancel_opposites(input logic [3:0] held);
      logic [3:0] k;
      k[0] = held[0] & ~held[1];
      k[1] = held[1] & ~held[0];
      k[2] = held[2] & ~held[3];
      k[3] = held[3] & ~held[2];
      return k;
   endfunction

endpackage

// File: rtl/kbd_arrow_decoder_ps2_rx.sv
// PS/2 frame receiver: synchroniser, glitch filter on ps2_clk, falling-edge detect,
// frame FSM with odd-parity/stop check and a mid-frame inactivity timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RX_IDLE   | waiting for a start bit (data=0 on a filtered clock fall)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | next fall carries the parity bit
// RX_STOP   | next fall carries the stop bit; byte is checked and emitted
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   rx_state_e     state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_err_q, rx_err_d;
   logic          fall;
   logic          timeout;

   always_ff @(posedge pclk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= RX_IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tcnt_q     <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tcnt_q     <= tcnt_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
      end
   end

   // Filter flips only on the FILTER_LEN-th consecutive sample of the new level.
   always_comb begin
      clk_s1_d = ps2_clk;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_data;
      dat_s2_d = dat_s1_q;
      filt_d   = filt_q;
      fcnt_d   = '0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FILT_LAST) begin
            filt_d = clk_s2_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   assign fall    = filt_q & ~filt_d;
   assign timeout = (state_q != RX_IDLE) && (tcnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = RX_IDLE;
      end else if (fall) begin
         case (state_q)
            RX_IDLE:   if (!dat_s2_q) state_d = RX_DATA;
            RX_DATA:   if (bitcnt_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: state_d = RX_STOP;
            RX_STOP:   state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      tcnt_d     = (state_q == RX_IDLE || fall) ? '0 : tcnt_q + 1'b1;
      if (timeout) begin
         rx_err_d = 1'b1;
         tcnt_d   = '0;
      end else if (fall) begin
         case (state_q)
            RX_IDLE: bitcnt_d = '0;
            RX_DATA: begin
               shift_d  = {dat_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 1'b1;
            end
            RX_PARITY: par_d = dat_s2_q;
            RX_STOP: begin
               if ((^shift_q ^ par_q) && dat_s2_q) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rx_byte  = rx_byte_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;

endmodule

// File: rtl/kbd_arrow_decoder.sv
// PS/2 keyboard front end: make/break decode of the arrow keys into a cancelled-opposites key vector.
// Define KBD_WASD_EN to also map non-extended W/A/S/D onto the same held bits.
module kbd_arrow_decoder
   import kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic [3:0] held_q, held_d;
   logic [3:0] key_q, key_d;
   logic [3:0] code_mask;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .pclk     (pclk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   function automatic logic [3:0] scan_mask(input logic [7:0] code, input logic ext);
      logic [3:0] m;
      m = '0;
      if (ext) begin
         case (code)
            SC_UP:    m = ARROW_UP;
            SC_DOWN:  m = ARROW_DOWN;
            SC_LEFT:  m = ARROW_LEFT;
            SC_RIGHT: m = ARROW_RIGHT;
            default:  m = '0;
         endcase
      end
`ifdef KBD_WASD_EN
      else begin
         case (code)
            SC_W:    m = ARROW_UP;
            SC_S:    m = ARROW_DOWN;
            SC_A:    m = ARROW_LEFT;
            SC_D:    m = ARROW_RIGHT;
            default: m = '0;
         endcase
      end
`endif
      return m;
   endfunction

   always_ff @(posedge pclk) begin
      if (rst) begin
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         held_q <= '0;
         key_q  <= '0;
      end else begin
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         held_q <= held_d;
         key_q  <= key_d;
      end
   end

   assign code_mask = scan_mask(rx_byte, ext_q);

   // Prefix bytes only arm flags; any final code byte consumes both flags.
   always_comb begin
      ext_d  = ext_q;
      brk_d  = brk_q;
      held_d = held_q;
      if (rx_err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk_d = 1'b1;
         end else begin
            if (!ext_q && (rx_byte == SC_BAT_OK || rx_byte == SC_BAT_ERR)) begin
               held_d = '0;
            end else if (brk_q) begin
               held_d = held_q & ~code_mask;
            end else begin
               held_d = held_q | code_mask;
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
      // Computed from held_d so key lands the cycle after the final rx_valid.
      key_d = cancel_opposites(held_d);
   end

   assign key = key_q;

endmodule

// File: tb/tb_kbd_arrow_decoder.sv
// Scoreboarded bench for kbd_arrow_decoder: PS/2 frames driven from a task, expected bytes/keys
// from a scancode-level model, checked by an independent monitor.
`timescale 1ns/1ps
module tb_kbd_arrow_decoder;

   localparam int FILT = 8;
   localparam int TMO  = 300;
   localparam int HALF = 20;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] key;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;

   kbd_arrow_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
      .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key(key), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
      logic [3:0] key;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: pressed state per direction (0=up 1=down 2=left 3=right) plus prefix flags.
   bit held[4];
   bit m_ext, m_brk;

   function automatic logic [3:0] model_key();
      logic [3:0] k;
      k[0] = held[0] && !held[1];
      k[1] = held[1] && !held[0];
      k[2] = held[2] && !held[3];
      k[3] = held[3] && !held[2];
      return k;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) held[i] = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int dir;
      dir = -1;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (!m_ext && (b == 8'hAA || b == 8'hFC)) begin
            for (int i = 0; i < 4; i++) held[i] = 1'b0;
         end else if (m_ext) begin
            case (b)
               8'h75: dir = 0;
               8'h72: dir = 1;
               8'h6B: dir = 2;
               8'h74: dir = 3;
               default: dir = -1;
            endcase
         end else begin
`ifdef KBD_WASD_EN
            case (b)
               8'h1D: dir = 0;
               8'h1B: dir = 1;
               8'h1C: dir = 2;
               8'h23: dir = 3;
               default: dir = -1;
            endcase
`endif
         end
         if (dir >= 0) held[dir] = !m_brk;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // Drives the first n bits of a frame (start, data LSB first, parity, stop).
   task automatic drive_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int n);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         tick(HALF);
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
      exp_t e;
      if (bad_par || bad_stop) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
         e = '{is_err: 1'b1, data: 8'h00, key: model_key()};
      end else begin
         model_byte(b);
         e = '{is_err: 1'b0, data: b, key: model_key()};
      end
      sb.push_back(e);
      drive_bits(b, bad_par, bad_stop, 11);
      ps2_data = 1'b1;
      tick(3 * HALF);
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && sb.size() != 0; i++) tick(1);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
         sb.delete();
      end
      tick(4);
   endtask

   initial begin : monitor
      exp_t       e;
      bit         pend;
      logic [3:0] pk;
      pend = 1'b0;
      pk   = '0;
      forever begin
         @(negedge pclk);
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               check("key_after_byte", {4'h0, key}, {4'h0, pk});
               pend = 1'b0;
            end
            if (rx_valid || rx_err) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_output: rx_valid=%0b rx_err=%0b rx_byte=%h, expected no output",
                           rx_valid, rx_err, rx_byte);
               end else begin
                  e = sb.pop_front();
                  check("rx_err_pulse", {7'h0, rx_err}, {7'h0, e.is_err});
                  check("rx_valid_pulse", {7'h0, rx_valid}, {7'h0, !e.is_err});
                  if (!e.is_err) check("rx_byte", rx_byte, e.data);
                  pend = 1'b1;
                  pk   = e.key;
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [7:0] codes [12];
      logic [7:0] b;
      codes = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFC, 8'h1D, 8'h1B, 8'h1C, 8'h23};
      model_reset();
      tick(5);
      check("reset_key", {4'h0, key}, 8'h00);
      check("reset_rx_byte", rx_byte, 8'h00);
      check("reset_rx_valid", {7'h0, rx_valid}, 8'h00);
      check("reset_rx_err", {7'h0, rx_err}, 8'h00);
      rst = 1'b0;
      tick(50);

      send(8'hE0); send(8'h75); drain();
      check("up_press", {4'h0, key}, 8'h01);
      send(8'hE0); send(8'hF0); send(8'h75); drain();
      check("up_release", {4'h0, key}, 8'h00);

      send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B); drain();
      check("diag_up_left", {4'h0, key}, 8'h05);
      send(8'hE0); send(8'h72); drain();
      check("cancel_up_down", {4'h0, key}, 8'h04);
      send(8'hE0); send(8'hF0); send(8'h72); drain();
      check("uncancel", {4'h0, key}, 8'h05);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h6B); drain();
      check("all_released", {4'h0, key}, 8'h00);

      send(8'hE0); send(8'h75, 1'b1); drain();
      check("parity_err_key", {4'h0, key}, 8'h00);
      send(8'h75); drain();
      check("plain_75_ignored", {4'h0, key}, 8'h00);

      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      tick(3);
      ps2_clk  = 1'b1;
      tick(2);
      ps2_data = 1'b1;
      tick(60);
      sb.push_back('{is_err: 1'b1, data: 8'h00, key: model_key()});
      m_ext = 1'b0;
      m_brk = 1'b0;
      drive_bits(8'h5A, 1'b0, 1'b0, 5);
      ps2_data = 1'b1;
      tick(TMO + 100);
      drain();
      send(8'hE0); send(8'h74); drain();
      check("after_timeout_right", {4'h0, key}, 8'h08);
      send(8'hE0); send(8'hF0); send(8'h74);
      send(8'hE0); send(8'h75); drain();
      check("up_before_reset", {4'h0, key}, 8'h01);

      drive_bits(8'h6B, 1'b0, 1'b0, 4);
      rst = 1'b1;
      sb.delete();
      model_reset();
      tick(1);
      check("midframe_rst_key", {4'h0, key}, 8'h00);
      check("midframe_rst_valid", {7'h0, rx_valid}, 8'h00);
      tick(1);
      rst = 1'b0;
      ps2_data = 1'b1;
      tick(50);
      send(8'hE0); send(8'h6B); drain();
      check("after_reset_left", {4'h0, key}, 8'h04);
      send(8'hE0); send(8'hF0); send(8'h6B); drain();

      send(8'h1D); drain();
`ifdef KBD_WASD_EN
      check("wasd_w", {4'h0, key}, 8'h01);
`else
      check("wasd_w", {4'h0, key}, 8'h00);
`endif
      send(8'hF0); send(8'h1D); drain();
      check("wasd_w_release", {4'h0, key}, 8'h00);
      send(8'hE0); send(8'h74); send(8'hAA); drain();
      check("bat_clears", {4'h0, key}, 8'h00);

      for (int n = 0; n < 45; n++) begin
         if ($urandom_range(0, 9) == 0) b = 8'($urandom);
         else b = codes[$urandom_range(0, 11)];
         if ($urandom_range(0, 2) == 0) b = 8'hE0;
         send(b, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
